delay_chain_param: RTL and testbench

DELAY_CHAIN_PARAM -- requirements
Module: delay_chain_param

---
 rtl/delay_chain_param.sv | 143 ++++++++++++++
 tb/tb_delay_chain_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/delay_chain_param.sv
// ---------------------------------------------------------------------------
// delay_chain_param
//   Parameterised tapped delay line, for example the sample history of a FIR
//   filter. One sample enters tap 0 on every enabled clock edge, and every
//   other tap takes the value of the tap below it. Samples are never modified.
//
// Parameters
//   DATA_W  sample width in bits (1..32)
//   DEPTH   number of taps (2..64)
//   SEL_W   width of the tap-select index (2**SEL_W >= DEPTH)
//
// Ports
//   iClk        clock; all state changes on the rising edge
//   iRst        asynchronous active-high reset; clears all state
//   iEnDelay    shift enable
//   iClear      synchronous flush of taps, fill count, drop and tap-select
//   iFirIn      input sample
//   iTapSel     index of the tap copied to oTapSel
//   oTapAll     all taps flattened; tap k at [k*DATA_W +: DATA_W]; tap 0 newest
//   oTap        oldest tap (DEPTH-1), taken straight from the register
//   oTapSel     registered copy of tap[iTapSel] (0 when the index is out of range)
//   oFillCnt    number of taps holding valid samples; saturates at DEPTH
//   oFull       oFillCnt == DEPTH
//   oDrop       sample shifted out of the oldest tap
//   oDropValid  one-cycle strobe qualifying oDrop
// ---------------------------------------------------------------------------
module delay_chain_param #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 10,
  parameter int SEL_W  = 4
) (
  input  logic                             iClk,
  input  logic                             iRst,
  input  logic                             iEnDelay,
  input  logic                             iClear,
  input  logic [DATA_W-1:0]                iFirIn,
  input  logic [SEL_W-1:0]                 iTapSel,
  output logic [DEPTH*DATA_W-1:0]          oTapAll,
  output logic [DATA_W-1:0]                oTap,
  output logic [DATA_W-1:0]                oTapSel,
  output logic [$clog2(DEPTH+1)-1:0]       oFillCnt,
  output logic                             oFull,
  output logic [DATA_W-1:0]                oDrop,
  output logic                             oDropValid
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [DATA_W-1:0] tap_reg [DEPTH];
  logic [DATA_W-1:0] tap_in  [DEPTH];
  logic [CNT_W-1:0]  fill_reg;
  logic [DATA_W-1:0] drop_reg;
  logic              drop_valid_reg;
  logic [DATA_W-1:0] tap_sel_reg;
  logic [DATA_W-1:0] tap_sel_next;
  logic              full;

  assign full = (fill_reg == CNT_MAX);

  // Shift source for every tap: tap 0 loads the new sample, tap k the tap
  // below it. Also flattens the taps onto the wide output bus.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign tap_in[gi] = iFirIn;
      end else begin : g_body
        assign tap_in[gi] = tap_reg[gi-1];
      end
      assign oTapAll[gi*DATA_W +: DATA_W] = tap_reg[gi];
    end
  endgenerate

  // Tap-select mux. An index with no matching tap (>= DEPTH) falls through
  // to zero, so no out-of-range array access is ever generated.
  always_comb begin
    tap_sel_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (iTapSel == SEL_W'(k)) begin
        tap_sel_next = tap_reg[k];
      end
    end
  end

  // Tap storage
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int k = 0; k < DEPTH; k++) tap_reg[k] <= '0;
    end else if (iClear) begin
      for (int k = 0; k < DEPTH; k++) tap_reg[k] <= '0;
    end else if (iEnDelay) begin
      for (int k = 0; k < DEPTH; k++) tap_reg[k] <= tap_in[k];
    end
  end

  // Fill counter: counts enabled shifts until every tap holds a real sample.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      fill_reg <= '0;
    end else if (iClear) begin
      fill_reg <= '0;
    end else if (iEnDelay && !full) begin
      fill_reg <= fill_reg + 1'b1;
    end
  end

  // Drop port. A sample only counts as dropped once the chain was full
  // before the edge; the zeros pushed out during fill are never flagged,
  // and oDrop keeps its last real value while no strobe is given.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      drop_reg       <= '0;
      drop_valid_reg <= 1'b0;
    end else if (iClear) begin
      drop_reg       <= '0;
      drop_valid_reg <= 1'b0;
    end else if (iEnDelay && full) begin
      drop_reg       <= tap_reg[DEPTH-1];
      drop_valid_reg <= 1'b1;
    end else begin
      drop_valid_reg <= 1'b0;
    end
  end

  // The tap-select register updates on every edge, whether or not the chain shifts.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      tap_sel_reg <= '0;
    end else if (iClear) begin
      tap_sel_reg <= '0;
    end else begin
      tap_sel_reg <= tap_sel_next;
    end
  end

  assign oTap       = tap_reg[DEPTH-1];
  assign oTapSel    = tap_sel_reg;
  assign oFillCnt   = fill_reg;
  assign oFull      = full;
  assign oDrop      = drop_reg;
  assign oDropValid = drop_valid_reg;

endmodule

// File: tb/tb_delay_chain_param.sv
// ---------------------------------------------------------------------------
// tb_delay_chain_param
//   Directed test of delay_chain_param at its default parameters, followed
//   by a random stretch checked against a behavioural history model.
// ---------------------------------------------------------------------------
module tb_delay_chain_param;

  localparam int DATA_W = 3;
  localparam int DEPTH  = 10;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                    iClk = 1'b0;
  logic                    iRst = 1'b0;
  logic                    iEnDelay = 1'b0;
  logic                    iClear = 1'b0;
  logic [DATA_W-1:0]       iFirIn = '0;
  logic [SEL_W-1:0]        iTapSel = '0;
  logic [DEPTH*DATA_W-1:0] oTapAll;
  logic [DATA_W-1:0]       oTap;
  logic [DATA_W-1:0]       oTapSel;
  logic [CNT_W-1:0]        oFillCnt;
  logic                    oFull;
  logic [DATA_W-1:0]       oDrop;
  logic                    oDropValid;

  delay_chain_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
    .iClk(iClk), .iRst(iRst), .iEnDelay(iEnDelay), .iClear(iClear),
    .iFirIn(iFirIn), .iTapSel(iTapSel), .oTapAll(oTapAll), .oTap(oTap),
    .oTapSel(oTapSel), .oFillCnt(oFillCnt), .oFull(oFull), .oDrop(oDrop),
    .oDropValid(oDropValid)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int passes = 0;

  // Model state: sample history (index 0 newest) and the registered outputs
  int unsigned m_tap [DEPTH];
  int unsigned m_fill, m_drop, m_dv, m_sel;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) m_tap[k] = 0;
    m_fill = 0; m_drop = 0; m_dv = 0; m_sel = 0;
  endtask

  // Advance the model by one edge, using the values held before the edge.
  task automatic model_edge(input bit en, input bit clr, input int unsigned din,
                            input int unsigned sel);
    int unsigned nsel;
    nsel = (sel < DEPTH) ? m_tap[sel] : 0;
    if (clr) begin
      model_reset();
    end else begin
      m_sel = nsel;
      if (en) begin
        m_dv = (m_fill == DEPTH) ? 1 : 0;
        if (m_dv != 0) m_drop = m_tap[DEPTH-1];
        for (int k = DEPTH - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
        m_tap[0] = din;
        if (m_fill < DEPTH) m_fill++;
      end else begin
        m_dv = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [DEPTH*DATA_W-1:0] packed_taps;
    for (int k = 0; k < DEPTH; k++) packed_taps[k*DATA_W +: DATA_W] = DATA_W'(m_tap[k]);
    chk({tag, ".taps"},  64'(oTapAll),   64'(packed_taps));
    chk({tag, ".fill"},  64'(oFillCnt),  64'(m_fill));
    chk({tag, ".full"},  64'(oFull),     64'(m_fill == DEPTH));
    chk({tag, ".drop"},  64'(oDrop),     64'(m_drop));
    chk({tag, ".dv"},    64'(oDropValid),64'(m_dv));
    chk({tag, ".sel"},   64'(oTapSel),   64'(m_sel));
    chk({tag, ".otap"},  64'(oTap),      64'(m_tap[DEPTH-1]));
  endtask

  // One clock: drive inputs on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input bit en, input bit clr, input int unsigned din,
                      input int unsigned sel, input string tag);
    @(negedge iClk);
    iEnDelay = en; iClear = clr; iFirIn = DATA_W'(din); iTapSel = SEL_W'(sel);
    @(posedge iClk);
    model_edge(en, clr, din, sel);
    #1;
    check_model(tag);
  endtask

  initial begin
    model_reset();

    // Asynchronous reset before any clock edge
    #1 iRst = 1'b1;
    #2;
    chk("rst.taps", 64'(oTapAll), 64'd0);
    chk("rst.fill", 64'(oFillCnt), 64'd0);
    chk("rst.full", 64'(oFull), 64'd0);
    chk("rst.dv",   64'(oDropValid), 64'd0);
    chk("rst.drop", 64'(oDrop), 64'd0);
    chk("rst.sel",  64'(oTapSel), 64'd0);
    // Inputs are ignored while reset is held
    iEnDelay = 1'b1; iFirIn = 3'd5;
    @(posedge iClk); #1;
    chk("rst_hold.taps", 64'(oTapAll), 64'd0);
    @(negedge iClk);
    iRst = 1'b0; iEnDelay = 1'b0;

    // Fill with 1..7,0,1,2; drop strobe must stay low throughout
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, (i + 1) % 8, 0, "fill");
      chk("fill.nodrop", 64'(oDropValid), 64'd0);
    end
    chk("fill.otap", 64'(oTap), 64'd1);
    chk("fill.tap0", 64'(oTapAll[2:0]), 64'd2);
    chk("fill.full", 64'(oFull), 64'd1);
    chk("fill.cnt",  64'(oFillCnt), 64'd10);
    chk("fill.all",  64'(oTapAll),
        64'({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2}));

    // Tap select: tap 9, then out-of-range 12, then tap 0
    step(1'b0, 1'b0, 0, 9, "sel9");
    chk("sel9.val", 64'(oTapSel), 64'd1);
    step(1'b0, 1'b0, 0, 12, "sel12");
    chk("sel12.val", 64'(oTapSel), 64'd0);
    step(1'b0, 1'b0, 0, 0, "sel0");
    chk("sel0.val", 64'(oTapSel), 64'd2);

    // One more shift drops the oldest sample
    step(1'b1, 1'b0, 3, 0, "drop");
    chk("drop.val",  64'(oDrop), 64'd1);
    chk("drop.dv",   64'(oDropValid), 64'd1);
    chk("drop.otap", 64'(oTap), 64'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 6, 0, "hold");
      chk("hold.dv",   64'(oDropValid), 64'd0);
      chk("hold.drop", 64'(oDrop), 64'd1);
      chk("hold.all",  64'(oTapAll),
          64'({3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3}));
    end

    // Clear beats enable; the incoming sample is discarded
    step(1'b1, 1'b1, 5, 3, "clear");
    chk("clear.all",  64'(oTapAll), 64'd0);
    chk("clear.cnt",  64'(oFillCnt), 64'd0);
    chk("clear.full", 64'(oFull), 64'd0);
    chk("clear.dv",   64'(oDropValid), 64'd0);

    // Reset mid-fill, asserted between edges
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3, 1, "prefill");
    @(negedge iClk);
    iEnDelay = 1'b0;
    #2 iRst = 1'b1;
    #1;
    model_reset();
    chk("midrst.all",  64'(oTapAll), 64'd0);
    chk("midrst.cnt",  64'(oFillCnt), 64'd0);
    chk("midrst.sel",  64'(oTapSel), 64'd0);
    iEnDelay = 1'b1; iFirIn = 3'd7;
    @(posedge iClk); #1;
    check_model("midrst_hold");
    @(negedge iClk);
    iRst = 1'b0; iEnDelay = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6, 2, "refill");
    chk("refill.cnt",  64'(oFillCnt), 64'd4);
    chk("refill.full", 64'(oFull), 64'd0);
    chk("refill.all",  64'(oTapAll), 64'({18'd0, 3'd6, 3'd6, 3'd6, 3'd6}));

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
           $urandom_range(0, 7), $urandom_range(0, 15), "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time limit so the bench always ends on its own
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
